// File: rtl/mfcc_pkg.sv
// Shared definitions for the MFCC front end.
// Holds the frame scheduler state encoding, the sample RAM address width,
// the largest supported frame and the start-up configuration legality test.
package mfcc_pkg;

   localparam int FRAME_ADDR_W = 8;
   localparam int MAX_FRAME    = 255;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      READ = 2'd2
   } frame_sched_state_t;

   // A frame needs at least two samples and must advance by at least one
   // sample per hop, otherwise the base pointer would never move.
   function automatic logic cfg_legal(input logic [7:0] fs, input logic [7:0] ov);
      return (fs >= 8'd2) && (ov < fs);
   endfunction

endpackage

// File: rtl/frame_scheduler_if.sv
// Sample-write and window-read handshake bundle of the frame scheduler.
//   preemph_valid : new pre-emphasis sample present (producer -> scheduler)
//   wr_en/wr_addr : sample RAM write strobe and address (scheduler -> RAM)
//   rd_valid/rd_ready : read burst handshake with the windowing stage
//   rd_addr/win_idx   : RAM read address and Hamming coefficient index
//   frame_first/frame_last : first/last element markers of a frame
// master = frame scheduler, slave = sample source plus windowing stage.
interface frame_scheduler_if
   import mfcc_pkg::*;
#(
   parameter int ADDR_W = FRAME_ADDR_W
);

   logic              preemph_valid;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic              rd_valid;
   logic              rd_ready;
   logic [ADDR_W-1:0] rd_addr;
   logic [7:0]        win_idx;
   logic              frame_first;
   logic              frame_last;

   modport master (
      input  preemph_valid,
      input  rd_ready,
      output wr_en,
      output wr_addr,
      output rd_valid,
      output rd_addr,
      output win_idx,
      output frame_first,
      output frame_last
   );

   modport slave (
      output preemph_valid,
      output rd_ready,
      input  wr_en,
      input  wr_addr,
      input  rd_valid,
      input  rd_addr,
      input  win_idx,
      input  frame_first,
      input  frame_last
   );

endinterface

// File: rtl/frame_scheduler.sv
// Framing stage sequencer for the MFCC front end.
// Writes incoming samples into a circular 2^ADDR_W sample RAM and, once a
// full frame is buffered, issues a back-pressured read burst (RAM address
// plus Hamming index). After each frame the base moves forward by the hop.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   en                         : run enable
//   frame_size, frame_overlap  : frame geometry, latched when leaving IDLE
//   bus (master)               : sample write and window read handshakes
//   frame_count                : completed frames (wraps)
//   overflow, cfg_err          : sticky dropped-sample / bad-config flags
//   busy                       : scheduler not in IDLE
//
// state | meaning
// IDLE  | stopped; waits for en with a legal configuration
// FILL  | collecting samples until a whole frame is buffered
// READ  | streaming the current frame to the windowing stage
module frame_scheduler
   import mfcc_pkg::*;
#(
   parameter int ADDR_W = FRAME_ADDR_W,
   parameter int CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [7:0]           frame_size,
   input  logic [7:0]           frame_overlap,
   frame_scheduler_if.master    bus,
   output logic [CNT_W-1:0]     frame_count,
   output logic                 overflow,
   output logic                 cfg_err,
   output logic                 busy
);

   localparam int              DEPTH   = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

   frame_sched_state_t state_q, state_d;
   logic [7:0]         fs_q, fs_d;
   logic [7:0]         hop_q, hop_d;
   logic [7:0]         k_q, k_d;
   logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]  base_q, base_d;
   logic [ADDR_W:0]    avail_q, avail_d;
   logic [CNT_W-1:0]   frame_count_q, frame_count_d;
   logic               overflow_q, overflow_d;
   logic               cfg_err_q, cfg_err_d;
   logic               rd_valid_q, rd_valid_d;
   logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
   logic [7:0]         win_idx_q, win_idx_d;
   logic               first_q, first_d;
   logic               last_q, last_d;

   logic               wr_go;
   logic               xfer;
   logic               last_xfer;
   logic [ADDR_W:0]    fs_ext;
   logic [ADDR_W:0]    hop_ext;

   assign fs_ext  = (ADDR_W + 1)'(fs_q);
   assign hop_ext = (ADDR_W + 1)'(hop_q);

   // Writes are refused once every RAM slot holds an unreleased sample.
   assign wr_go     = (state_q != IDLE) && bus.preemph_valid && (avail_q < DEPTH_V);
   // rd_valid_q mirrors state_q == READ, so the state can qualify the handshake.
   assign xfer      = (state_q == READ) && bus.rd_ready;
   assign last_xfer = xfer && (k_q == fs_q - 8'd1);

   always_comb begin
      state_d       = state_q;
      fs_d          = fs_q;
      hop_d         = hop_q;
      k_d           = k_q;
      wr_ptr_d      = wr_ptr_q;
      base_d        = base_q;
      avail_d       = avail_q;
      frame_count_d = frame_count_q;
      overflow_d    = overflow_q;
      cfg_err_d     = cfg_err_q;

      if (state_q != IDLE) begin
         if (wr_go) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            avail_d  = avail_q + 1'b1;
         end
         if (bus.preemph_valid && (avail_q == DEPTH_V)) begin
            overflow_d = 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            if (en) begin
               if (cfg_legal(frame_size, frame_overlap)) begin
                  fs_d     = frame_size;
                  hop_d    = frame_size - frame_overlap;
                  wr_ptr_d = '0;
                  base_d   = '0;
                  avail_d  = '0;
                  k_d      = '0;
                  state_d  = FILL;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         FILL: begin
            if (avail_q >= fs_ext) begin
               k_d     = '0;
               state_d = READ;
            end else if (!en) begin
               state_d = IDLE;
            end
         end
         READ: begin
            if (last_xfer) begin
               // avail_d already carries a same-cycle write; release the hop on top.
               base_d        = base_q + ADDR_W'(hop_q);
               avail_d       = avail_d - hop_ext;
               frame_count_d = frame_count_q + 1'b1;
               k_d           = '0;
               if (!en) begin
                  state_d = IDLE;
               end else if (avail_d >= fs_ext) begin
                  state_d = READ;
               end else begin
                  state_d = FILL;
               end
            end else if (xfer) begin
               k_d = k_q + 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Read-side outputs are registered from next-state values, so on a stall
   // they hold automatically because base/k do not change.
   always_comb begin
      rd_valid_d = (state_d == READ);
      rd_addr_d  = base_d + ADDR_W'(k_d);
      win_idx_d  = k_d;
      first_d    = rd_valid_d && (k_d == 8'd0);
      last_d     = rd_valid_d && (k_d == fs_d - 8'd1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         fs_q          <= '0;
         hop_q         <= '0;
         k_q           <= '0;
         wr_ptr_q      <= '0;
         base_q        <= '0;
         avail_q       <= '0;
         frame_count_q <= '0;
         overflow_q    <= 1'b0;
         cfg_err_q     <= 1'b0;
         rd_valid_q    <= 1'b0;
         rd_addr_q     <= '0;
         win_idx_q     <= '0;
         first_q       <= 1'b0;
         last_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         fs_q          <= fs_d;
         hop_q         <= hop_d;
         k_q           <= k_d;
         wr_ptr_q      <= wr_ptr_d;
         base_q        <= base_d;
         avail_q       <= avail_d;
         frame_count_q <= frame_count_d;
         overflow_q    <= overflow_d;
         cfg_err_q     <= cfg_err_d;
         rd_valid_q    <= rd_valid_d;
         rd_addr_q     <= rd_addr_d;
         win_idx_q     <= win_idx_d;
         first_q       <= first_d;
         last_q        <= last_d;
      end
   end

   assign bus.wr_en       = wr_go;
   assign bus.wr_addr     = wr_ptr_q;
   assign bus.rd_valid    = rd_valid_q;
   assign bus.rd_addr     = rd_addr_q;
   assign bus.win_idx     = win_idx_q;
   assign bus.frame_first = first_q;
   assign bus.frame_last  = last_q;
   assign frame_count     = frame_count_q;
   assign overflow        = overflow_q;
   assign cfg_err         = cfg_err_q;
   assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_frame_scheduler.sv
module tb_frame_scheduler;
   import mfcc_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [7:0]  frame_size;
   logic [7:0]  frame_overlap;
   logic [15:0] frame_count;
   logic        overflow;
   logic        cfg_err;
   logic        busy;

   always #5 clk = ~clk;

   frame_scheduler_if #(.ADDR_W(8)) bus ();

   frame_scheduler #(.ADDR_W(8), .CNT_W(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .en            (en),
      .frame_size    (frame_size),
      .frame_overlap (frame_overlap),
      .bus           (bus.master),
      .frame_count   (frame_count),
      .overflow      (overflow),
      .cfg_err       (cfg_err),
      .busy          (busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // transfer monitor
   int xf_addr[$];
   int xf_k[$];
   int xf_first[$];
   int xf_last[$];
   int frames_done = 0;
   int wr_cnt = 0;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_addr = '0;
   logic [7:0] prev_k = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (bus.wr_en) wr_cnt++;
         if (prev_stall && bus.rd_valid) begin
            check("stall_hold_addr", bus.rd_addr, prev_addr);
            check("stall_hold_idx", bus.win_idx, prev_k);
         end
         if (bus.rd_valid && bus.rd_ready) begin
            xf_addr.push_back(int'(bus.rd_addr));
            xf_k.push_back(int'(bus.win_idx));
            xf_first.push_back(int'(bus.frame_first));
            xf_last.push_back(int'(bus.frame_last));
            if (bus.frame_last) frames_done++;
         end
         prev_stall = bus.rd_valid && !bus.rd_ready;
         prev_addr  = bus.rd_addr;
         prev_k     = bus.win_idx;
      end
   end

   task automatic clear_mon();
      xf_addr.delete();
      xf_k.delete();
      xf_first.delete();
      xf_last.delete();
      frames_done = 0;
      wr_cnt = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      en = 1'b0;
      bus.preemph_valid = 1'b0;
      bus.rd_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      clear_mon();
      rst_n = 1'b1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_wr_en"}, bus.wr_en, 0);
      check({tag, "_wr_addr"}, bus.wr_addr, 0);
      check({tag, "_rd_valid"}, bus.rd_valid, 0);
      check({tag, "_rd_addr"}, bus.rd_addr, 0);
      check({tag, "_win_idx"}, bus.win_idx, 0);
      check({tag, "_first"}, bus.frame_first, 0);
      check({tag, "_last"}, bus.frame_last, 0);
      check({tag, "_frame_count"}, frame_count, 0);
      check({tag, "_overflow"}, overflow, 0);
      check({tag, "_cfg_err"}, cfg_err, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   typedef struct {
      int fs;
      int ov;
      int n;
      bit toggle;
      int exp_frames;
      int exp_wr_addr;
   } vec_t;

   vec_t vecs[5];

   task automatic run_vec(input int id, input vec_t v);
      int sent = 0;
      int cyc = 0;
      int hop = v.fs - v.ov;
      int w = 0;
      int n_exp = v.exp_frames * v.fs;
      int n_cmp;
      do_reset();
      frame_size = 8'(v.fs);
      frame_overlap = 8'(v.ov);
      en = 1'b1;
      bus.rd_ready = 1'b1;
      while (cyc < 3000 && !(sent == v.n && xf_addr.size() >= n_exp)) begin
         @(posedge clk);
         #1;
         cyc++;
         // keep unreleased samples safely below RAM depth so none are dropped
         if (busy && sent < v.n && (sent - frames_done * hop) < 250) begin
            bus.preemph_valid = 1'b1;
            sent++;
         end else begin
            bus.preemph_valid = 1'b0;
         end
         bus.rd_ready = v.toggle ? !bus.rd_ready : 1'b1;
      end
      check($sformatf("vec%0d_in_budget", id), (cyc < 3000), 1);
      @(posedge clk);
      #1;
      bus.preemph_valid = 1'b0;
      bus.rd_ready = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check($sformatf("vec%0d_xfer_count", id), xf_addr.size(), n_exp);
      n_cmp = (xf_addr.size() < n_exp) ? xf_addr.size() : n_exp;
      for (int i = 0; i < n_cmp; i++) begin
         int f = i / v.fs;
         int k = i % v.fs;
         check($sformatf("vec%0d_addr_%0d", id, i), xf_addr[i], (f * hop + k) % 256);
         check($sformatf("vec%0d_k_%0d", id, i), xf_k[i], k);
         check($sformatf("vec%0d_first_%0d", id, i), xf_first[i], (k == 0) ? 1 : 0);
         check($sformatf("vec%0d_last_%0d", id, i), xf_last[i], (k == v.fs - 1) ? 1 : 0);
      end
      check($sformatf("vec%0d_frame_count", id), frame_count, v.exp_frames);
      check($sformatf("vec%0d_wr_addr", id), bus.wr_addr, v.exp_wr_addr);
      check($sformatf("vec%0d_overflow", id), overflow, 0);
      check($sformatf("vec%0d_cfg_err", id), cfg_err, 0);
      en = 1'b0;
      while (busy && w < 50) begin
         @(posedge clk);
         #1;
         w++;
      end
      check($sformatf("vec%0d_idle_after_en_low", id), busy, 0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int sent;
      int found;
      frame_size = 8'd8;
      frame_overlap = 8'd4;
      vecs[0] = '{fs: 8,   ov: 4, n: 12,  toggle: 1'b0, exp_frames: 2, exp_wr_addr: 12};
      vecs[1] = '{fs: 8,   ov: 4, n: 12,  toggle: 1'b1, exp_frames: 2, exp_wr_addr: 12};
      vecs[2] = '{fs: 200, ov: 0, n: 400, toggle: 1'b0, exp_frames: 2, exp_wr_addr: 144};
      vecs[3] = '{fs: 5,   ov: 2, n: 17,  toggle: 1'b0, exp_frames: 5, exp_wr_addr: 17};
      vecs[4] = '{fs: 2,   ov: 1, n: 6,   toggle: 1'b1, exp_frames: 5, exp_wr_addr: 6};

      // reset values, with a sample offered while idle
      do_reset();
      bus.preemph_valid = 1'b1;
      @(negedge clk);
      check_reset_outputs("rst");
      bus.preemph_valid = 1'b0;

      for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

      // start and launch latency: fs=4, ov=0
      do_reset();
      frame_size = 8'd4;
      frame_overlap = 8'd0;
      bus.rd_ready = 1'b1;
      @(posedge clk); #1;
      en = 1'b1;
      @(negedge clk);
      check("start_busy_same_cycle", busy, 0);
      @(posedge clk); #1;
      bus.preemph_valid = 1'b1;
      @(negedge clk);
      check("start_busy_next_cycle", busy, 1);
      check("start_wr_en", bus.wr_en, 1);
      repeat (3) begin
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      bus.preemph_valid = 1'b0;
      @(negedge clk);
      check("launch_t1_rd_valid", bus.rd_valid, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("launch_t2_rd_valid", bus.rd_valid, 1);
      check("launch_t2_rd_addr", bus.rd_addr, 0);
      check("launch_t2_first", bus.frame_first, 1);
      repeat (6) @(posedge clk);
      #1;
      check("launch_frame_count", frame_count, 1);
      check("launch_wr_addr", bus.wr_addr, 4);
      check("launch_fill_busy", busy, 1);
      check("launch_xfers", xf_addr.size(), 4);

      // overflow: rd_ready low, 300 samples offered
      do_reset();
      frame_size = 8'd16;
      frame_overlap = 8'd8;
      en = 1'b1;
      @(posedge clk); #1;
      bus.preemph_valid = 1'b1;
      repeat (300) @(posedge clk);
      #1;
      bus.preemph_valid = 1'b0;
      @(negedge clk);
      check("ovf_writes", wr_cnt, 256);
      check("ovf_flag", overflow, 1);
      check("ovf_wr_addr", bus.wr_addr, 0);
      check("ovf_rd_valid", bus.rd_valid, 1);
      check("ovf_rd_addr_held", bus.rd_addr, 0);
      @(posedge clk); #1;
      bus.rd_ready = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("ovf_drain_enough", (xf_addr.size() >= 16), 1);
      for (int i = 0; i < 16 && i < xf_addr.size(); i++) begin
         check($sformatf("ovf_drain_addr_%0d", i), xf_addr[i], i);
      end
      check("ovf_sticky", overflow, 1);

      // illegal configurations
      do_reset();
      frame_size = 8'd4;
      frame_overlap = 8'd4;
      en = 1'b1;
      bus.preemph_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("cfg_eq_err", cfg_err, 1);
      check("cfg_eq_busy", busy, 0);
      check("cfg_eq_no_wr", wr_cnt, 0);
      do_reset();
      check("cfg_err_cleared", cfg_err, 0);
      frame_size = 8'd1;
      frame_overlap = 8'd0;
      en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("cfg_fs1_err", cfg_err, 1);
      check("cfg_fs1_busy", busy, 0);

      // reset at k=3 of frame 2
      do_reset();
      frame_size = 8'd8;
      frame_overlap = 8'd4;
      bus.rd_ready = 1'b1;
      en = 1'b1;
      sent = 0;
      found = 0;
      for (int c = 0; c < 200 && found == 0; c++) begin
         @(posedge clk); #1;
         bus.preemph_valid = (sent < 20);
         if (sent < 20) sent++;
         @(negedge clk);
         if (bus.rd_valid && frames_done == 2 && bus.win_idx == 8'd3) found = 1;
      end
      check("midrst_reached", found, 1);
      check("midrst_addr_before", bus.rd_addr, 11);
      rst_n = 1'b0;
      #1;
      bus.preemph_valid = 1'b1;
      #1;
      check_reset_outputs("midrst");
      @(posedge clk); #1;
      bus.preemph_valid = 1'b0;
      en = 1'b0;
      clear_mon();
      rst_n = 1'b1;
      @(posedge clk); #1;
      en = 1'b1;
      @(posedge clk); #1;
      sent = 0;
      for (int c = 0; c < 40 && xf_addr.size() == 0; c++) begin
         bus.preemph_valid = (sent < 8);
         if (sent < 8) sent++;
         @(posedge clk); #1;
      end
      bus.preemph_valid = 1'b0;
      check("restart_got_xfer", (xf_addr.size() > 0), 1);
      if (xf_addr.size() > 0) begin
         check("restart_addr0", xf_addr[0], 0);
         check("restart_first", xf_first[0], 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
